alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq_mdu_iter.sv | 60 ++++++
 rtl/alu_seq.sv | 99 +++++++++
 tb/tb_alu_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants shared with the existing ALU and the alu_seq state encoding
package alu_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} state_t;
endpackage

// File: rtl/alu_seq_mdu_iter.sv
// mdu_iter: iterative Booth multiply / non-restoring divide on one shared adder; ports clk, clr(low), load, div_mode, run, fix, a, b -> last, res
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic               div_mode,
  input  logic               run,
  input  logic               fix,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] res
);
  logic [WIDTH:0] acc, x, y, sum;
  logic [WIDTH-1:0] q, m, rem, quo, hi;
  logic [SHW-1:0] cnt;
  logic q1, dm, neg_q, neg_r, sub, b_add, b_sub;
  always_comb begin
    b_add = ~q[0] & q1;
    b_sub = q[0] & ~q1;
    x = (dm && !fix) ? {acc[WIDTH-1:0], q[WIDTH-1]} : acc;
    y = dm ? ((fix && !acc[WIDTH]) ? '0 : {1'b0, m}) : ((b_add | b_sub) ? {m[WIDTH-1], m} : '0);
    sub = dm ? (!fix && !acc[WIDTH]) : b_sub;
    sum = x + (sub ? ~y : y) + {{WIDTH{1'b0}}, sub};
    rem = sum[WIDTH-1:0];
    quo = neg_q ? -q : q;
    hi = neg_r ? -rem : rem;
    res = dm ? {hi, quo} : {sum, q[WIDTH-1:1]};
    last = &cnt;
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      acc <= '0;
      q <= '0;
      m <= '0;
      q1 <= 1'b0;
      dm <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      q <= (div_mode && a[WIDTH-1]) ? -a : a;
      m <= (div_mode && b[WIDTH-1]) ? -b : b;
      q1 <= 1'b0;
      dm <= div_mode;
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
      cnt <= '0;
    end else if (run) begin
      acc <= dm ? sum : {sum[WIDTH], sum[WIDTH:1]};
      q <= dm ? {q[WIDTH-2:0], ~sum[WIDTH]} : {sum[0], q[WIDTH-1:1]};
      q1 <= q[0];
      cnt <= cnt + SHW'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with iterative MUL/DIV; ports clk, clr(low), start, opcode, A, B -> busy, done, C{hi,lo}, dz
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C,
  output logic               dz
);
  state_t state;
  logic [2*WIDTH-1:0] sc, mres;
  logic [WIDTH-1:0] lo;
  logic [SHW-1:0] sh;
  logic [SHW:0] rsh;
  logic accept, go_mul, go_div, last;
  always_comb begin
    accept = state == ST_IDLE && start;
    go_mul = opcode == OP_MUL;
    go_div = opcode == OP_DIV && B != '0;
    sh = B[SHW-1:0];
    rsh = (SHW+1)'(WIDTH) - {1'b0, sh};
    case (opcode)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_BR, OP_ADDI: lo = A + B;
      OP_SUB: lo = A - B;
      OP_AND, OP_ANDI: lo = A & B;
      OP_OR, OP_ORI: lo = A | B;
      OP_ROR: lo = (A >> sh) | (A << rsh);
      OP_ROL: lo = (A << sh) | (A >> rsh);
      OP_SHR: lo = A >> sh;
      OP_SHRA: lo = $signed(A) >>> sh;
      OP_SHL: lo = A << sh;
      OP_NEG: lo = -A;
      OP_NOT: lo = ~A;
      OP_DIV: lo = '1;
      default: lo = '0;
    endcase
    sc = {(opcode == OP_DIV) ? A : {WIDTH{1'b0}}, lo};
  end
  mdu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_mdu (
    .clk(clk),
    .clr(clr),
    .load(accept),
    .div_mode(opcode == OP_DIV),
    .run(state == ST_MUL || state == ST_DIV),
    .fix(state == ST_FIX),
    .a(A),
    .b(B),
    .last(last),
    .res(mres)
  );
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      C <= '0;
      dz <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          busy <= 1'b1;
          state <= go_mul ? ST_MUL : go_div ? ST_DIV : ST_DONE;
          if (!go_mul && !go_div) begin
            done <= 1'b1;
            C <= sc;
            dz <= opcode == OP_DIV;
          end
        end
        ST_MUL: if (last) begin
          state <= ST_DONE;
          done <= 1'b1;
          C <= mres;
          dz <= 1'b0;
        end
        ST_DIV: if (last) state <= ST_FIX;
        ST_FIX: begin
          state <= ST_DONE;
          done <= 1'b1;
          C <= mres;
          dz <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors plus a cycle-level reference model for alu_seq at WIDTH=32
module tb_alu_seq;
  import alu_pkg::*;
  logic clk = 0, clr = 0, start = 0;
  logic [4:0] opcode = '0;
  logic [31:0] A = '0, B = '0;
  logic busy, done, dz;
  logic [63:0] C;
  int errors = 0, checks = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .opcode(opcode), .A(A), .B(B),
    .busy(busy), .done(done), .C(C), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Result of an operation straight from the arithmetic rules: {dz, C}
  function automatic logic [64:0] ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    logic [4:0] s;
    logic signed [31:0] qq, rr;
    logic signed [63:0] p;
    s = b[4:0];
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_BR, OP_ADDI: return {33'b0, a + b};
      OP_SUB: return {33'b0, a - b};
      OP_AND, OP_ANDI: return {33'b0, a & b};
      OP_OR, OP_ORI: return {33'b0, a | b};
      OP_ROR: begin t = {a, a} >> s; return {33'b0, t[31:0]}; end
      OP_ROL: begin t = {a, a} << s; return {33'b0, t[63:32]}; end
      OP_SHR: return {33'b0, a >> s};
      OP_SHRA: begin qq = $signed(a) >>> s; return {33'b0, qq}; end
      OP_SHL: return {33'b0, a << s};
      OP_NEG: return {33'b0, -a};
      OP_NOT: return {33'b0, ~a};
      OP_MUL: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return {1'b0, p};
      end
      OP_DIV: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {33'b0, a};
        qq = $signed(a) / $signed(b);
        rr = $signed(a) % $signed(b);
        return {1'b0, rr, qq};
      end
      default: return '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] b);
    return op == OP_MUL ? 33 : (op == OP_DIV && b != 0) ? 34 : 1;
  endfunction

  logic m_busy = 0, m_done = 0, m_dz = 0;
  logic [63:0] m_c = '0;
  logic [64:0] m_pend = '0;
  int m_rem = 0;
  logic c_clr, c_st;
  logic [4:0] c_op;
  logic [31:0] c_a, c_b;

  // Reference model: latency countdown per accepted request, compared every cycle
  always @(posedge clk) begin
    c_clr = clr; c_st = start; c_op = opcode; c_a = A; c_b = B;
    #1;
    if (!c_clr) begin
      m_busy = 0; m_done = 0; m_c = '0; m_dz = 0; m_rem = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin m_done = 1; {m_dz, m_c} = m_pend; end
    end else if (c_st) begin
      m_busy = 1;
      m_pend = ref_op(c_op, c_a, c_b);
      m_rem = ref_lat(c_op, c_b) - 1;
      if (m_rem == 0) begin m_done = 1; {m_dz, m_c} = m_pend; end
    end
    chk("model_busy", {63'b0, busy}, {63'b0, m_busy});
    chk("model_done", {63'b0, done}, {63'b0, m_done});
    chk("model_C", C, m_c);
    chk("model_dz", {63'b0, dz}, {63'b0, m_dz});
  end

  task automatic do_op(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] ec, input logic edz, input int elat);
    int k;
    @(negedge clk);
    start = 1; opcode = op; A = a; B = b;
    @(negedge clk);
    start = 0;
    k = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_lat"}, 64'(k), 64'(elat));
    chk({nm, "_C"}, C, ec);
    chk({nm, "_dz"}, {63'b0, dz}, {63'b0, edz});
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_C", C, 64'd0);
    chk("rst_dz", {63'b0, dz}, 64'd0);
    clr = 1;
    do_op("add", OP_ADD, 32'd7, 32'd5, 64'h0000000C, 0, 1);
    do_op("not", OP_NOT, 32'd0, 32'd0, 64'h00000000_FFFFFFFF, 0, 1);
    do_op("mul_neg", OP_MUL, 32'hFFFFFFFD, 32'd6, 64'hFFFFFFFF_FFFFFFEE, 0, 33);
    do_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0, 34);
    do_op("div_zero", OP_DIV, 32'd9, 32'd0, 64'h00000009_FFFFFFFF, 1, 1);
    do_op("shra", OP_SHRA, 32'h80000000, 32'd33, 64'h00000000_C0000000, 0, 1);
    do_op("rol", OP_ROL, 32'h80000001, 32'd4, 64'h00000018, 0, 1);
    do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0, 34);
    do_op("div_negb", OP_DIV, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 0, 34);
    do_op("mul_min", OP_MUL, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 0, 33);
    do_op("mul_pos", OP_MUL, 32'd12345, 32'd678, 64'd8369910, 0, 33);
    do_op("sub", OP_SUB, 32'd5, 32'd7, 64'h00000000_FFFFFFFE, 0, 1);
    do_op("ror", OP_ROR, 32'd1, 32'd1, 64'h00000000_80000000, 0, 1);
    do_op("shl", OP_SHL, 32'd1, 32'd31, 64'h00000000_80000000, 0, 1);
    do_op("shr", OP_SHR, 32'h80000000, 32'd4, 64'h08000000, 0, 1);
    do_op("neg", OP_NEG, 32'd1, 32'd0, 64'h00000000_FFFFFFFF, 0, 1);
    do_op("andi", OP_ANDI, 32'hF0F0F0F0, 32'h0FF00FF0, 64'h00F000F0, 0, 1);
    do_op("ori", OP_ORI, 32'hF0000000, 32'h0000000F, 64'hF000000F, 0, 1);
    do_op("div_zero2", OP_DIV, 32'd3, 32'd0, 64'h00000003_FFFFFFFF, 1, 1);
    do_op("unlisted", 5'b11111, 32'd3, 32'd4, 64'd0, 0, 1);
    // start held high with single-cycle ops: one accept every 2 cycles
    @(negedge clk);
    start = 1; opcode = OP_ADD; A = 32'd1; B = 32'd1;
    n = 0;
    repeat (6) begin @(negedge clk); if (done) n++; end
    start = 0;
    chk("b2b_dones", 64'(n), 64'd3);
    // start held high through a DIV: exactly one completion
    @(negedge clk);
    start = 1; opcode = OP_DIV; A = 32'd100; B = 32'd7;
    n = 0;
    for (int i = 0; i < 60 && n == 0; i++) begin @(negedge clk); if (done) n++; end
    start = 0;
    repeat (3) begin @(negedge clk); if (done) n++; end
    chk("div_hold_dones", 64'(n), 64'd1);
    chk("div_hold_C", C, 64'h00000002_0000000E);
    // reset in the middle of a MUL, start kept high throughout
    @(negedge clk);
    start = 1; opcode = OP_MUL; A = 32'd5; B = 32'd7;
    repeat (11) @(negedge clk);
    clr = 0;
    @(negedge clk);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_C", C, 64'd0);
    clr = 1; opcode = OP_ADD; A = 32'd1; B = 32'd2;
    @(negedge clk);
    start = 0;
    chk("post_rst_done", {63'b0, done}, 64'd1);
    chk("post_rst_C", C, 64'd3);
    n = 0;
    repeat (40) begin @(negedge clk); if (done) n++; end
    chk("abort_no_late_done", 64'(n), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
